// File: rtl/ring_meter_pkg.sv
// ---------------------------------------------------------------------------
// ring_meter_pkg
// Shared definitions for the ring-oscillator frequency meter:
//   - state_t       : measurement FSM state encoding
//   - bin2gray      : binary -> Gray conversion (CNT_W_MAX wide, zero-extend narrower counts)
//   - gray2bin      : Gray -> binary conversion (CNT_W_MAX wide, zero-extend narrower codes)
//   - readout width constants (DATA_W, SEL_W, BYTE_W, CNT_W_MAX)
// ---------------------------------------------------------------------------
package ring_meter_pkg;

    // Readout bus geometry
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned SEL_W     = 4;
    localparam int unsigned BYTE_W    = 2;
    // Widest supported counter; also the span addressable by i_byte (4 bytes)
    localparam int unsigned CNT_W_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Gray code of a zero-extended count is the zero-extended Gray code,
    // so callers may widen, convert and truncate back.
    function automatic logic [CNT_W_MAX-1:0] bin2gray(input logic [CNT_W_MAX-1:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [CNT_W_MAX-1:0] gray2bin(input logic [CNT_W_MAX-1:0] i_gray);
        logic [CNT_W_MAX-1:0] v_bin;
        v_bin = i_gray;
        for (int unsigned i = 1; i < CNT_W_MAX; i++) begin
            v_bin = v_bin ^ (i_gray >> i);
        end
        return v_bin;
    endfunction

endpackage

// File: rtl/ring_meter_if.sv
// ---------------------------------------------------------------------------
// ring_meter_if
// Control / readout bus of ring_meter.
//   i_start : begin a measurement (level, sampled on i_clk)
//   i_sel   : channel index for readout
//   i_byte  : byte index (0 = LSB) of the selected result
//   o_busy  : measurement in progress
//   o_done  : result valid, held until next start or reset
//   o_data  : registered readout byte
// Modports: master drives the controls, slave is the meter.
// ---------------------------------------------------------------------------
interface ring_meter_if;
    import ring_meter_pkg::*;

    logic                i_start;
    logic [SEL_W-1:0]    i_sel;
    logic [BYTE_W-1:0]   i_byte;
    logic                o_busy;
    logic                o_done;
    logic [DATA_W-1:0]   o_data;

    modport master (
        output i_start,
        output i_sel,
        output i_byte,
        input  o_busy,
        input  o_done,
        input  o_data
    );

    modport slave (
        input  i_start,
        input  i_sel,
        input  i_byte,
        output o_busy,
        output o_done,
        output o_data
    );

endinterface

// File: rtl/ring_gray_cnt.sv
// ---------------------------------------------------------------------------
// ring_gray_cnt
// One measurement channel in its own ring-oscillator clock domain:
// resynchronised reset, free-running binary edge counter and a registered
// Gray copy of the count that is safe to sample from another clock domain.
//   i_ring_clk : ring-oscillator clock (counts its rising edges)
//   i_rst      : system reset from the i_clk domain (active-high)
//   o_gray     : Gray-coded edge count, registered in the ring domain
// ---------------------------------------------------------------------------
module ring_gray_cnt
    import ring_meter_pkg::*;
#(
    parameter int unsigned pCNT_W = 16
) (
    input  logic              i_ring_clk,
    input  logic              i_rst,
    output logic [pCNT_W-1:0] o_gray
);

    logic [1:0]        r_rst_sync;
    logic [pCNT_W-1:0] r_cnt;
    logic [pCNT_W-1:0] r_gray;
    logic [pCNT_W-1:0] w_cnt_nxt;
    logic [pCNT_W-1:0] w_gray_nxt;

    assign w_cnt_nxt  = r_cnt + pCNT_W'(1);
    // Gray register tracks the next count so it stays equal to r_cnt
    assign w_gray_nxt = pCNT_W'(bin2gray(CNT_W_MAX'(w_cnt_nxt)));

    // Bring the system reset into the ring domain
    always_ff @(posedge i_ring_clk) begin
        r_rst_sync <= {r_rst_sync[0], i_rst};
    end

    // Edge counter and its Gray image, reset synchronously in the ring domain
    always_ff @(posedge i_ring_clk) begin
        if (r_rst_sync[1]) begin
            r_cnt  <= '0;
            r_gray <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_gray <= w_gray_nxt;
        end
    end

    assign o_gray = r_gray;

endmodule

// File: rtl/ring_meter.sv
// ---------------------------------------------------------------------------
// ring_meter
// Measures the number of rising edges of pCHANNELS ring-oscillator clocks
// over a window of pWINDOW i_clk cycles. Each ring count is Gray-coded in
// its own domain, synchronised into i_clk, converted back to binary and
// snapshotted at window start and end; the modular difference is the result.
//   i_clk      : reference clock for control and readout
//   i_rst      : synchronous active-high reset
//   i_ring_clk : pCHANNELS free-running ring clocks (asynchronous)
//   io_bus     : control / readout bus (start, sel, byte, busy, done, data)
// ---------------------------------------------------------------------------
module ring_meter
    import ring_meter_pkg::*;
#(
    parameter int unsigned pCHANNELS = 4,
    parameter int unsigned pCNT_W    = 16,
    parameter int unsigned pWINDOW   = 1000,
    parameter int unsigned pSYNC     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [pCHANNELS-1:0] i_ring_clk,
    ring_meter_if.slave          io_bus
);

    localparam int unsigned      WIN_W    = $clog2(pWINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(pWINDOW - 1);

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [DATA_W-1:0]  r_data;
    logic [WIN_W-1:0]   r_win_cnt;

    logic [pCNT_W-1:0]  w_gray   [pCHANNELS];
    logic [pCNT_W-1:0]  r_sync   [pCHANNELS][pSYNC];
    logic [pCNT_W-1:0]  w_now    [pCHANNELS];
    logic [pCNT_W-1:0]  r_snap0  [pCHANNELS];
    logic [pCNT_W-1:0]  r_result [pCHANNELS];

    logic [CNT_W_MAX-1:0] w_rd_word;
    logic [DATA_W-1:0]    w_rd_byte;

    // Per-channel ring-domain counters and Gray conversion back to binary
    for (genvar g_ch = 0; g_ch < pCHANNELS; g_ch++) begin : g_chan
        ring_gray_cnt #(
            .pCNT_W (pCNT_W)
        ) u_cnt (
            .i_ring_clk (i_ring_clk[g_ch]),
            .i_rst      (i_rst),
            .o_gray     (w_gray[g_ch])
        );

        assign w_now[g_ch] = pCNT_W'(gray2bin(CNT_W_MAX'(r_sync[g_ch][pSYNC-1])));
    end

    // Gray-code synchronisers; only one bit changes per ring edge, so any
    // sampled value is either the old or the new count.
    always_ff @(posedge i_clk) begin
        for (int unsigned ch = 0; ch < pCHANNELS; ch++) begin
            r_sync[ch][0] <= w_gray[ch];
            for (int unsigned s = 1; s < pSYNC; s++) begin
                r_sync[ch][s] <= r_sync[ch][s-1];
            end
        end
    end

    // Measurement FSM with window counter, snapshots and results
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_win_cnt <= '0;
            for (int unsigned ch = 0; ch < pCHANNELS; ch++) begin
                r_snap0[ch]  <= '0;
                r_result[ch] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (io_bus.i_start) begin
                        r_state   <= ST_MEASURE;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_win_cnt <= '0;
                        for (int unsigned ch = 0; ch < pCHANNELS; ch++) begin
                            r_snap0[ch] <= w_now[ch];
                        end
                    end
                end
                ST_MEASURE: begin
                    // r_win_cnt holds k-1 before edge t+k, so the closing
                    // capture lands exactly on edge t+pWINDOW.
                    if (r_win_cnt == WIN_LAST) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_win_cnt <= '0;
                        for (int unsigned ch = 0; ch < pCHANNELS; ch++) begin
                            r_result[ch] <= w_now[ch] - r_snap0[ch];
                        end
                    end else begin
                        r_win_cnt <= r_win_cnt + WIN_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Readout select: unknown channels read as zero, results zero-extended
    always_comb begin
        w_rd_word = '0;
        w_rd_byte = '0;
        for (int unsigned ch = 0; ch < pCHANNELS; ch++) begin
            if (io_bus.i_sel == SEL_W'(ch)) begin
                w_rd_word = CNT_W_MAX'(r_result[ch]);
            end
        end
        case (io_bus.i_byte)
            2'd0:    w_rd_byte = w_rd_word[7:0];
            2'd1:    w_rd_byte = w_rd_word[15:8];
            2'd2:    w_rd_byte = w_rd_word[23:16];
            default: w_rd_byte = w_rd_word[31:24];
        endcase
    end

    // Registered readout byte
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= '0;
        end else begin
            r_data <= w_rd_byte;
        end
    end

    assign io_bus.o_busy = r_busy;
    assign io_bus.o_done = r_done;
    assign io_bus.o_data = r_data;

endmodule

// File: tb/tb_ring_meter.sv
// ---------------------------------------------------------------------------
// tb_ring_meter
// Directed bench for ring_meter. Three instances share i_clk (40 ns) and
// i_rst; ring clocks of 10/20/40/80 ns are offset so their rising edges
// never coincide with i_clk edges.
//   u_a : 4 ch, 16-bit, window 100   (basic, busy-restart, reset-mid-measure)
//   u_b : 1 ch,  8-bit, window 100   (counter wrap)
//   u_c : 4 ch, 16-bit, window 1165  (10 ns ring on ch2 -> 4660 = 0x1234)
// ---------------------------------------------------------------------------
module tb_ring_meter;
    import ring_meter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r10 = 1'b0;
    logic r20 = 1'b0;
    logic r40 = 1'b0;
    logic r80 = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    ring_meter_if a_if ();
    ring_meter_if b_if ();
    ring_meter_if c_if ();

    ring_meter #(.pCHANNELS(4), .pCNT_W(16), .pWINDOW(100), .pSYNC(2)) u_a (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ring_clk ({r80, r40, r20, r10}),
        .io_bus     (a_if)
    );

    ring_meter #(.pCHANNELS(1), .pCNT_W(8), .pWINDOW(100), .pSYNC(2)) u_b (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ring_clk (r10),
        .io_bus     (b_if)
    );

    ring_meter #(.pCHANNELS(4), .pCNT_W(16), .pWINDOW(1165), .pSYNC(2)) u_c (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ring_clk ({r80, r10, r20, r40}),
        .io_bus     (c_if)
    );

    // Clocks: i_clk rises at 20+40k; rings rise at 6+10k, 11+20k, 21+40k, 41+80k
    initial forever #20 clk = ~clk;
    initial begin #1; forever #5  r10 = ~r10; end
    initial begin #1; forever #10 r20 = ~r20; end
    initial begin #1; forever #20 r40 = ~r40; end
    initial begin #1; forever #40 r80 = ~r80; end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp, input int tol = 0);
        longint d;
        n_vec++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_a(input int ch, output int v);
        logic [7:0] lo;
        logic [7:0] hi;
        a_if.i_sel  = 4'(ch);
        a_if.i_byte = 2'd0;
        tick();
        lo = a_if.o_data;
        a_if.i_byte = 2'd1;
        tick();
        hi = a_if.o_data;
        v = int'({hi, lo});
    endtask

    initial begin
        int v;
        int nlow;
        int exp_a [4];
        exp_a[0] = 400; exp_a[1] = 200; exp_a[2] = 100; exp_a[3] = 50;

        a_if.i_start = 1'b0; a_if.i_sel = '0; a_if.i_byte = '0;
        b_if.i_start = 1'b0; b_if.i_sel = '0; b_if.i_byte = '0;
        c_if.i_start = 1'b0; c_if.i_sel = '0; c_if.i_byte = '0;

        // Reset: held long enough for the slowest ring domain to see it
        rst = 1'b1;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", a_if.o_busy, 0);
        chk("rst_done", a_if.o_done, 0);
        chk("rst_b_done", b_if.o_done, 0);
        for (int s = 0; s < 5; s++) begin
            for (int b = 0; b < 4; b++) begin
                a_if.i_sel  = 4'(s);
                a_if.i_byte = 2'(b);
                tick();
                chk($sformatf("rst_data_s%0d_b%0d", s, b), a_if.o_data, 0);
            end
        end
        repeat (20) tick();

        // Basic measurement on u_a and wrap on u_b, started together
        a_if.i_start = 1'b1;
        b_if.i_start = 1'b1;
        tick();
        a_if.i_start = 1'b0;
        b_if.i_start = 1'b0;
        chk("basic_busy_t", a_if.o_busy, 1);
        chk("basic_done_t", a_if.o_done, 0);
        repeat (99) tick();
        chk("basic_busy_t99", a_if.o_busy, 1);
        chk("basic_done_t99", a_if.o_done, 0);
        tick();
        chk("basic_done_t100", a_if.o_done, 1);
        chk("basic_busy_t100", a_if.o_busy, 0);
        chk("wrap_done_t100", b_if.o_done, 1);
        for (int ch = 0; ch < 4; ch++) begin
            read_a(ch, v);
            chk($sformatf("basic_ch%0d", ch), v, exp_a[ch], 2);
        end
        b_if.i_sel = 4'd0; b_if.i_byte = 2'd0;
        tick();
        chk("wrap_ch0", b_if.o_data, 144, 2);
        b_if.i_byte = 2'd1;
        tick();
        chk("wrap_byte1", b_if.o_data, 0);

        // Restart from DONE, then a second start while busy must be ignored
        a_if.i_start = 1'b1;
        tick();
        a_if.i_start = 1'b0;
        chk("rs_done_cleared", a_if.o_done, 0);
        chk("rs_busy_t", a_if.o_busy, 1);
        read_a(0, v);
        chk("rs_old_result", v, 400, 2);
        nlow = 0;
        repeat (47) begin
            tick();
            if (!a_if.o_busy) nlow++;
        end
        a_if.i_start = 1'b1;
        tick();
        a_if.i_start = 1'b0;
        if (!a_if.o_busy) nlow++;
        repeat (49) begin
            tick();
            if (!a_if.o_busy) nlow++;
        end
        chk("rs_busy_cont", nlow, 0);
        chk("rs_done_t99", a_if.o_done, 0);
        tick();
        chk("rs_done_t100", a_if.o_done, 1);
        chk("rs_busy_t100", a_if.o_busy, 0);
        read_a(1, v);
        chk("rs_ch1", v, 200, 2);

        // Reset in the middle of a measurement
        a_if.i_start = 1'b1;
        tick();
        a_if.i_start = 1'b0;
        repeat (40) tick();
        rst = 1'b1;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        chk("mid_busy", a_if.o_busy, 0);
        chk("mid_done", a_if.o_done, 0);
        for (int ch = 0; ch < 4; ch++) begin
            read_a(ch, v);
            chk($sformatf("mid_res_ch%0d", ch), v, 0);
        end
        b_if.i_byte = 2'd0;
        tick();
        chk("mid_b_res", b_if.o_data, 0);
        repeat (20) tick();
        a_if.i_start = 1'b1;
        tick();
        a_if.i_start = 1'b0;
        repeat (99) tick();
        chk("post_done_t99", a_if.o_done, 0);
        tick();
        chk("post_done_t100", a_if.o_done, 1);
        read_a(2, v);
        chk("post_ch2", v, 100, 2);
        read_a(3, v);
        chk("post_ch3", v, 50, 2);

        // Readout byte mapping and latency on u_c (ch2 counts 4660 = 0x1234)
        c_if.i_start = 1'b1;
        tick();
        c_if.i_start = 1'b0;
        repeat (1164) tick();
        chk("rd_done_t1164", c_if.o_done, 0);
        tick();
        chk("rd_done_t1165", c_if.o_done, 1);
        c_if.i_sel = 4'd2; c_if.i_byte = 2'd1;
        tick();
        chk("rd_ch2_b1", c_if.o_data, 8'h12);
        c_if.i_byte = 2'd0;
        #1;
        chk("rd_latency_hold", c_if.o_data, 8'h12);
        tick();
        chk("rd_ch2_b0", c_if.o_data, 8'h34);
        c_if.i_byte = 2'd2;
        tick();
        chk("rd_ch2_b2", c_if.o_data, 0);
        c_if.i_byte = 2'd3;
        tick();
        chk("rd_ch2_b3", c_if.o_data, 0);
        c_if.i_byte = 2'd0;
        tick();
        chk("rd_ch2_b0_again", c_if.o_data, 8'h34);
        c_if.i_sel = 4'd5;
        #1;
        chk("rd_sel5_hold", c_if.o_data, 8'h34);
        tick();
        chk("rd_sel5", c_if.o_data, 0);
        c_if.i_sel = 4'd1; c_if.i_byte = 2'd0;
        tick();
        chk("rd_ch1_b0", c_if.o_data, 8'h1B, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ring_meter.md
RING_METER -- requirements
Module: ring_meter

Interface
REQ-001 Parameter pCHANNELS, default 4, number of ring-oscillator clock inputs measured (1..16).
REQ-002 Parameter pCNT_W, default 16, width of each per-channel edge counter and result (8..32).
REQ-003 Parameter pWINDOW, default 1000, measurement window length in i_clk cycles (>=4).
REQ-004 Parameter pSYNC, default 2, synchronizer depth for ring-to-i_clk crossing (>=2).
REQ-005 Clock i_clk, input, 1: system/reference clock; all control and readout logic runs on it.
REQ-006 Reset i_rst, input, 1: synchronous, active-high, on i_clk.
REQ-007 i_ring_clk, input, pCHANNELS: free-running ring-oscillator clocks, asynchronous to i_clk.
REQ-008 i_start, input, 1: level sampled each i_clk edge; high in IDLE or DONE begins a measurement.
REQ-009 i_sel, input, 4: channel index for readout.
REQ-010 i_byte, input, 2: byte index (0 = LSB) of the selected result.
REQ-011 o_busy, output, 1: high while a measurement is in progress.
REQ-012 o_done, output, 1: high from result-valid until the next start or reset.
REQ-013 o_data, output, 8: registered readout byte.

Function
REQ-014 Each channel SHALL hold a pCNT_W-bit binary counter clocked by its i_ring_clk, incremented every rising edge, and publish a Gray-coded register of that count.
REQ-015 Each Gray register SHALL cross into i_clk through pSYNC flops per bit, then be converted to binary ("now[ch]").
REQ-016 FSM states: IDLE, MEASURE, DONE; i_start in IDLE or DONE -> MEASURE; i_start in MEASURE is ignored.
REQ-017 i_start sampled high at edge t SHALL capture snap0[ch]=now[ch] for all channels at edge t and assert o_busy from edge t.
REQ-018 At edge t+pWINDOW the block SHALL write result[ch]=(now[ch]-snap0[ch]) mod 2^pCNT_W for all channels simultaneously, drop o_busy, assert o_done, enter DONE.
REQ-019 Window counter SHALL count exactly pWINDOW i_clk cycles between the two captures; no other latency.
REQ-020 Counter wrap: subtraction is modulo 2^pCNT_W; a channel exceeding 2^pCNT_W-1 edges per window aliases without flag.
REQ-021 result[] SHALL hold until the next REQ-018 update; a restart from DONE clears o_done at edge t but keeps the old results readable until overwritten.
REQ-022 o_data SHALL equal byte i_byte of result[i_sel], registered one cycle after i_sel/i_byte change.
REQ-023 o_data SHALL be 0 for i_sel>=pCHANNELS or for bytes entirely above pCNT_W; partial top byte zero-extended.

Reset
REQ-024 i_rst SHALL force IDLE, o_busy=0, o_done=0, o_data=0, window counter=0, all snap0 and result registers 0, including mid-measurement (measurement abandoned).
REQ-025 Each ring-domain counter SHALL reset to 0 via a 2-flop synchronized copy of i_rst applied synchronously in that ring domain; i_rst must be held >=4 i_clk cycles.

Structure
REQ-026 Package ring_meter_pkg SHALL hold the FSM state encoding, the bin-to-Gray and Gray-to-bin functions, and the readout width constants.
REQ-027 Sub-module ring_gray_cnt SHALL contain one channel's ring-domain reset synchronizer, binary counter and Gray register; ring_meter instantiates it pCHANNELS times.
REQ-028 Synchronizers, snapshot/result registers, FSM and readout mux reside in ring_meter.

Verification
REQ-029 Reset: hold i_rst 4 cycles -> o_busy=0, o_done=0, o_data=0 for every i_sel/i_byte.
REQ-030 Basic: pCHANNELS=4, pWINDOW=100, i_clk 40 ns, ring periods 10/20/40/80 ns -> results 400/200/100/50, each +-2; o_done high exactly at edge t+100.
REQ-031 Wrap: pCNT_W=8, ring 10 ns, i_clk 40 ns, pWINDOW=100 -> result 144 +-2.
REQ-032 Start while busy: pulse i_start at t and t+50 -> single capture at t+pWINDOW, o_busy continuous, no restart.
REQ-033 Reset mid-measure: i_rst at t+40 -> IDLE, o_busy=0, results 0; subsequent start measures normally.
REQ-034 Readout: pCNT_W=16, result 0x1234 on ch2 -> i_byte 0 gives 0x34, 1 gives 0x12, 2 gives 0x00; i_sel=5 gives 0x00, one cycle latency.
